// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared state encoding and default sizing for the interrupt controller
package intc_pkg;
  localparam int N_IRQ_DEF = 8;
  localparam int VEC_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SVC_MI  = 2'd1,
    SVC_NMI = 2'd2
  } intc_state_e;
endpackage

// File: rtl/intc_prio_enc.sv
// rtl/intc_prio_enc.sv - priority encoder whose search begins at base_i and wraps modulo N_IRQ
module intc_prio_enc #(
  parameter int N_IRQ = 8,
  parameter int VEC_W = 3
) (
  input  logic [N_IRQ-1:0] req_i,
  input  logic [VEC_W-1:0] base_i,
  output logic [VEC_W-1:0] vec_o,
  output logic             valid_o
);

  logic [VEC_W-1:0] idx;

  // Walk from the farthest candidate back to base so the nearest hit is written last.
  always_comb begin
    vec_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      idx = VEC_W'((int'(base_i) + i) % N_IRQ);
      if (req_i[idx]) begin
        vec_o   = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-latched IRQ/NMI source for the CPU control unit
// Define INTC_ROTATING_PRIO_EN for round-robin selection; fixed lowest-index priority otherwise.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEF,
  parameter int VEC_W = VEC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             nmi_in,
  input  logic             mask_wr,
  input  logic [N_IRQ-1:0] mask_data,
  input  logic             ack,
  input  logic             ina,
  input  logic             eoi,
  output logic             interrupt,
  output logic             nmint,
  output logic             busy,
  output logic [VEC_W-1:0] vector,
  output logic [N_IRQ-1:0] pending
);

  intc_state_e      state_q, state_d, base_state;
  logic [N_IRQ-1:0] irq_q, pending_q, pending_d, mask_q, eligible, clr;
  logic             nmi_q, nmi_pending_q, nmi_pending_d, nmi_clr;
  logic [VEC_W-1:0] isv_q, isv_d, enc_vec, base;
  logic             enc_valid;

`ifdef INTC_ROTATING_PRIO_EN
  logic [VEC_W-1:0] last_q;
  assign base = (last_q == VEC_W'(N_IRQ - 1)) ? '0 : last_q + 1'b1;
`else
  assign base = '0;
`endif

  assign eligible = pending_q & ~mask_q;

  intc_prio_enc #(.N_IRQ(N_IRQ), .VEC_W(VEC_W)) u_enc (
    .req_i   (eligible),
    .base_i  (base),
    .vec_o   (enc_vec),
    .valid_o (enc_valid)
  );

  assign interrupt = enc_valid;
  assign nmint     = nmi_pending_q && (state_q != SVC_NMI);
  assign busy      = (state_q != IDLE);
  assign vector    = (state_q == SVC_MI) ? isv_q : enc_vec;
  assign pending   = pending_q;

  // eoi retires the current service first, so an ack in the same cycle sees IDLE.
  always_comb begin
    base_state = (eoi && state_q != IDLE) ? IDLE : state_q;
    state_d    = base_state;
    isv_d      = isv_q;
    clr        = '0;
    nmi_clr    = 1'b0;
    case (base_state)
      IDLE: begin
        if (ack && ina && enc_valid) begin
          state_d = SVC_MI;
          isv_d   = enc_vec;
          clr     = N_IRQ'(1) << enc_vec;
        end else if (ack && !ina && nmi_pending_q) begin
          state_d = SVC_NMI;
          nmi_clr = 1'b1;
        end
      end
      SVC_MI: begin
        if (ack && !ina && nmi_pending_q) begin
          state_d = SVC_NMI;
          nmi_clr = 1'b1;
        end
      end
      default: ;
    endcase
    pending_d     = (pending_q & ~clr) | (irq_in & ~irq_q);
    nmi_pending_d = (nmi_pending_q & ~nmi_clr) | (nmi_in & ~nmi_q);
  end

  // Edge samplers track the inputs during reset so levels held across release stay quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      nmi_pending_q <= 1'b0;
      mask_q        <= '0;
      isv_q         <= '0;
      irq_q         <= irq_in;
      nmi_q         <= nmi_in;
`ifdef INTC_ROTATING_PRIO_EN
      last_q        <= VEC_W'(N_IRQ - 1);
`endif
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      nmi_pending_q <= nmi_pending_d;
      isv_q         <= isv_d;
      irq_q         <= irq_in;
      nmi_q         <= nmi_in;
      if (mask_wr) mask_q <= mask_data;
`ifdef INTC_ROTATING_PRIO_EN
      if (clr != '0) last_q <= enc_vec;
`endif
    end
  end

endmodule
